// File: rtl/pipeline_stall_ctrl.sv
// Purpose: per-stage write-enable/flush/bubble control for PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
// Latency: controls are combinational from state and hazards; halted and stall_count are registered.
// Backpressure: dcache_stall freezes the whole pipe and holds sequencing; icache_stall holds PC only.
module pipeline_stall_ctrl #(
    parameter int CTRL_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_hzd,
    input  logic             branch_hzd,
    input  logic             cntl_hzd,
    input  logic             is_hlt,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        CTRL_WAIT  = 2'd1,
        HALT_DRAIN = 2'd2,
        HALTED     = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       if_id_we_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= 4'd0;
            halted      <= 1'b0;
            stall_count <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            halted <= (state_nxt == HALTED);
            if (!pc_we && state != HALTED && stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + 1'b1;
        end
    end

    always_comb begin
        pc_we        = 1'b1;
        if_id_we_raw = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_we    = 1'b1;
        mem_wb_we    = 1'b1;
        state_nxt    = state;
        cnt_nxt      = cnt;

        if (dcache_stall) begin
            // full freeze: sequencing counters do not advance either
            pc_we        = 1'b0;
            if_id_we_raw = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_we    = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_hzd || branch_hzd) begin
                        pc_we        = 1'b0;
                        if_id_we_raw = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (icache_stall) begin
                        pc_we       = 1'b0;
                        if_id_flush = 1'b1;
                    end else if (cntl_hzd && is_hlt) begin
                        pc_we       = 1'b0;
                        if_id_flush = 1'b1;
                        state_nxt   = HALT_DRAIN;
                        cnt_nxt     = 4'(DRAIN_CYCLES);
                    end else if (cntl_hzd) begin
                        // transfer advances normally; its shadow is flushed from next cycle
                        state_nxt = CTRL_WAIT;
                        cnt_nxt   = 4'(CTRL_CYCLES);
                    end
                end
                CTRL_WAIT: begin
                    // PC stays writable so the redirect from EX/MEM can load
                    if_id_flush = 1'b1;
                    cnt_nxt     = cnt - 4'd1;
                    if (cnt == 4'd1)
                        state_nxt = RUN;
                end
                HALT_DRAIN: begin
                    pc_we        = 1'b0;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    cnt_nxt      = cnt - 4'd1;
                    if (cnt == 4'd1)
                        state_nxt = HALTED;
                end
                HALTED: begin
                    pc_we        = 1'b0;
                    if_id_we_raw = 1'b0;
                    ex_mem_we    = 1'b0;
                    mem_wb_we    = 1'b0;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end

        if_id_we = if_id_we_raw && !if_id_flush;
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: expected control vectors are queued at drive time
// and popped at the following negedge for comparison.
module tb_pipeline_stall_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_hzd, branch_hzd, cntl_hzd, is_hlt, icache_stall, dcache_stall;
    logic          pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we, halted;
    logic [CW-1:0] stall_count;

    pipeline_stall_ctrl #(.CTRL_CYCLES(2), .DRAIN_CYCLES(3), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .mem_hzd(mem_hzd), .branch_hzd(branch_hzd), .cntl_hzd(cntl_hzd), .is_hlt(is_hlt),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .halted(halted), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // input codes {mem, branch, cntl, hlt, icache, dcache}
    localparam logic [5:0] I0 = 6'b000000, IMEM = 6'b100000, IBR = 6'b010000,
                           ICTL = 6'b001000, IHLT = 6'b001100, IIC = 6'b000010,
                           IDC = 6'b000001;
    // output codes {pc_we, if_id_we, flush, bubble, ex_mem_we, mem_wb_we, halted}
    localparam logic [6:0] NORM = 7'b1100110, DHZ = 7'b0001110, FRZ = 7'b0000000,
                           IFL = 7'b0010110, CTW = 7'b1010110, DRN = 7'b0011110,
                           HLT = 7'b0000001;

    logic [10:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic step(input string tag, input logic [5:0] in, input logic [6:0] eo,
                        input logic [CW-1:0] ec);
        logic [10:0] got, exp;
        @(posedge clk);
        #1;
        rst = 1'b0;
        {mem_hzd, branch_hzd, cntl_hzd, is_hlt, icache_stall, dcache_stall} = in;
        exp_q.push_back({eo, ec});
        @(negedge clk);
        got = {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we, halted,
               stall_count};
        exp = exp_q.pop_front();
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                   tag, got[10:4], got[3:0], exp[10:4], exp[3:0]);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        {mem_hzd, branch_hzd, cntl_hzd, is_hlt, icache_stall, dcache_stall} = I0;
    endtask

    initial begin
        rst = 1'b1;
        {mem_hzd, branch_hzd, cntl_hzd, is_hlt, icache_stall, dcache_stall} = I0;
        do_reset();

        for (int i = 0; i < 5; i++) step("idle", I0, NORM, 4'd0);
        step("mem_hzd", IMEM, DHZ, 4'd0);
        step("after_mem_hzd", I0, NORM, 4'd1);

        step("br_accept", ICTL, NORM, 4'd1);
        step("br_flush1", I0, CTW, 4'd1);
        step("br_flush2", I0, CTW, 4'd1);
        step("br_done", I0, NORM, 4'd1);

        step("br2_accept", ICTL, NORM, 4'd1);
        step("dc_freeze1", IDC, FRZ, 4'd1);
        step("dc_freeze2", IDC | ICTL, FRZ, 4'd2);
        step("dc_freeze3", IDC, FRZ, 4'd3);
        step("br2_flush1", IMEM, CTW, 4'd4);
        step("br2_flush2", ICTL, CTW, 4'd4);
        step("br2_done", I0, NORM, 4'd4);

        step("prio_hzd_over_ctl", IMEM | ICTL, DHZ, 4'd4);
        step("ctl_dropped", I0, NORM, 4'd5);
        step("prio_hzd_over_ic", IBR | IIC, DHZ, 4'd5);
        step("icache", IIC | ICTL, IFL, 4'd6);
        step("ic_ctl_dropped", I0, NORM, 4'd7);

        do_reset();
        step("hlt_accept", IHLT, IFL, 4'd0);
        step("drain1", I0, DRN, 4'd1);
        step("drain2", IMEM, DRN, 4'd2);
        step("drain3", I0, DRN, 4'd3);
        step("halted1", I0, HLT, 4'd4);
        step("halted_hzd", IMEM | IIC, HLT, 4'd4);
        step("halted_ctl", ICTL, HLT, 4'd4);

        do_reset();
        step("hlt2_accept", IHLT, IFL, 4'd0);
        step("hlt2_drain1", I0, DRN, 4'd1);
        do_reset();
        step("rst_mid_drain", I0, NORM, 4'd0);

        step("br3_accept", ICTL, NORM, 4'd0);
        step("br3_dc", IDC, FRZ, 4'd0);
        do_reset();
        step("rst_mid_dc", I0, NORM, 4'd0);

        do_reset();
        for (int i = 0; i < 20; i++)
            step("sat_icache", IIC, IFL, (i > 15) ? 4'd15 : 4'(i));
        step("sat_hold", I0, NORM, 4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
